// File: rtl/if_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, instruction memory and decode.
//   master : the prefetch queue (drives requests and the decode-facing head)
//   slave  : the environment (memory + decode)
// Signals:
//   mem_req_valid/ready/addr   in-order read request channel
//   mem_resp_valid/data        in-order read response, one per accepted request
//   ins_valid/ready            decode handshake
//   ins/ins_pc/ins_pcp4        head instruction, its address and address+4
interface if_prefetch_queue_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic [31:0] ins_pcp4;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_addr,
        input  mem_resp_valid,
        input  mem_resp_data,
        output ins_valid,
        input  ins_ready,
        output ins,
        output ins_pc,
        output ins_pcp4
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_addr,
        output mem_resp_valid,
        output mem_resp_data,
        input  ins_valid,
        output ins_ready,
        input  ins,
        input  ins_pc,
        input  ins_pcp4
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue feeding decode.
// Owns the fetch PC, issues in-order reads to instruction memory, buffers the
// returned words with their PC in a DEPTH-entry FIFO and hands them to decode.
// A redirect flushes the FIFO and marks every in-flight read as stale.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   redirect     load redirect_pc as the new fetch PC and flush
//   redirect_pc  new word-aligned fetch address
//   bus          memory request/response and decode channels (master side)
// DEPTH must be a power of two and at least 2.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h80
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    if_prefetch_queue_if.master        bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned PW = $clog2(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [31:0] fetch_pc,    fetch_pc_n;
    logic [31:0] resp_pc,     resp_pc_n;
    cnt_t        count,       count_n;
    cnt_t        outstanding, outstanding_n;
    cnt_t        drop,        drop_n;
    ptr_t        rd_ptr,      rd_ptr_n;
    ptr_t        wr_ptr,      wr_ptr_n;
    logic        armed;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    cnt_t        live;
    logic        credit;
    logic        req_valid;
    logic        issue;
    logic        resp_ok;
    logic        push;
    logic        pop;

    // Handshake decode and next-state for all counters, pointers and PCs.
    always_comb begin
        live          = outstanding - drop;
        credit        = (SW'(count) + SW'(live)) < SW'(DEPTH);
        // armed holds requests off for the first cycle out of reset
        req_valid     = armed & ~redirect & credit;
        issue         = req_valid & bus.mem_req_ready;
        // a response with nothing outstanding is a protocol error and is ignored
        resp_ok       = bus.mem_resp_valid & (outstanding != '0);
        push          = resp_ok & ~redirect & (drop == '0);
        pop           = (count != '0) & bus.ins_ready & ~redirect;

        fetch_pc_n    = fetch_pc;
        resp_pc_n     = resp_pc;
        count_n       = count;
        drop_n        = drop;
        rd_ptr_n      = rd_ptr;
        wr_ptr_n      = wr_ptr;
        outstanding_n = outstanding + CW'(issue) - CW'(resp_ok);

        if (redirect) begin
            fetch_pc_n = redirect_pc;
            resp_pc_n  = redirect_pc;
            count_n    = '0;
            rd_ptr_n   = '0;
            wr_ptr_n   = '0;
            // everything still in flight after this edge is stale
            drop_n     = outstanding - CW'(resp_ok);
        end else begin
            if (issue) begin
                fetch_pc_n = fetch_pc + 32'd4;
            end
            if (resp_ok && (drop != '0)) begin
                drop_n = drop - CW'(1);
            end
            if (push) begin
                resp_pc_n = resp_pc + 32'd4;
                wr_ptr_n  = wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_n = rd_ptr + PW'(1);
            end
            count_n = count + CW'(push) - CW'(pop);
        end
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            armed       <= 1'b0;
        end else begin
            fetch_pc    <= fetch_pc_n;
            resp_pc     <= resp_pc_n;
            count       <= count_n;
            outstanding <= outstanding_n;
            drop        <= drop_n;
            rd_ptr      <= rd_ptr_n;
            wr_ptr      <= wr_ptr_n;
            armed       <= 1'b1;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            data_mem[wr_ptr] <= bus.mem_resp_data;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.ins_valid     = (count != '0);
    assign bus.ins           = data_mem[rd_ptr];
    assign bus.ins_pc        = pc_mem[rd_ptr];
    assign bus.ins_pcp4      = pc_mem[rd_ptr] + 32'd4;

    // Occupancy and in-flight bookkeeping sanity.
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop <= outstanding);
    a_outstanding_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue && !resp_ok && (outstanding == '1)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios, a queue-based reference
// model checked every cycle, and literal expectations per scenario.
module tb_if_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    if_prefetch_queue_if bus();

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h80)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // stimulus shadows, applied once per cycle by step()
    logic        d_rst_n = 1'b0;
    logic        d_redirect = 1'b0;
    logic [31:0] d_redirect_pc = 32'h0;
    logic        d_mem_ready = 1'b0;
    logic        d_ins_ready = 1'b0;
    int          lat = 1;

    typedef struct { logic [31:0] addr; int cyc; } mreq_t;
    typedef struct { logic [31:0] addr; bit stale; } fl_t;

    mreq_t       pipe[$];
    logic [31:0] issued[$];
    logic [31:0] delivered[$];

    // reference model
    logic [31:0] m_fifo[$];
    fl_t         m_inflight[$];
    logic [31:0] m_fetch = 32'h80;
    bit          m_armed = 1'b0;
    bit          m_ok = 1'b0;
    logic        exp_rv;
    bit          issue_m;
    bit          have_r;
    fl_t         r;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic int live_count();
        int n = 0;
        foreach (m_inflight[i]) if (!m_inflight[i].stale) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle of stimulus, including the memory response.
    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
        rst_n             = d_rst_n;
        redirect          = d_redirect;
        redirect_pc       = d_redirect_pc;
        bus.mem_req_ready = d_mem_ready;
        bus.ins_ready     = d_ins_ready;
        if (!d_rst_n) begin
            pipe.delete();
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = 32'h0;
        end else if (pipe.size() > 0 && cyc >= pipe[0].cyc + lat) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_word(pipe[0].addr);
            void'(pipe.pop_front());
        end else begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = 32'hdead_beef;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        d_rst_n    = 1'b0;
        d_redirect = 1'b0;
        run(2);
        d_rst_n = 1'b1;
        issued.delete();
        delivered.delete();
    endtask

    // Memory accepts requests.
    always @(negedge clk) begin
        #3;
        if (rst_n && bus.mem_req_valid && bus.mem_req_ready) begin
            pipe.push_back('{addr: bus.mem_req_addr, cyc: cyc});
            issued.push_back(bus.mem_req_addr);
        end
    end

    // Compare DUT against the model, then advance the model by one edge.
    always @(negedge clk) begin
        #2;
        exp_rv = m_armed && !redirect && ((m_fifo.size() + live_count()) < DEPTH);
        if (m_ok) begin
            chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(exp_rv));
            if (exp_rv) chk("mem_req_addr", bus.mem_req_addr, m_fetch);
            chk("ins_valid", 32'(bus.ins_valid), 32'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) begin
                chk("ins_pc", bus.ins_pc, m_fifo[0]);
                chk("ins", bus.ins, mem_word(m_fifo[0]));
                chk("ins_pcp4", bus.ins_pcp4, m_fifo[0] + 32'd4);
            end
        end
        if (rst_n && bus.ins_valid && bus.ins_ready && !redirect)
            delivered.push_back(bus.ins_pc);

        if (!rst_n) begin
            m_fifo.delete();
            m_inflight.delete();
            m_fetch = 32'h80;
            m_armed = 1'b0;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            issue_m = exp_rv && bus.mem_req_ready;
            have_r  = 1'b0;
            if (bus.mem_resp_valid) begin
                n_tests++;
                if (m_inflight.size() == 0) begin
                    n_fail++;
                    $display("FAIL protocol: response with nothing in flight (cycle %0d)", cyc);
                end else begin
                    r      = m_inflight.pop_front();
                    have_r = 1'b1;
                end
            end
            if (redirect) begin
                m_fifo.delete();
                foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
                m_fetch = redirect_pc;
            end else begin
                if (bus.ins_ready && m_fifo.size() != 0) void'(m_fifo.pop_front());
                if (have_r && !r.stale) m_fifo.push_back(r.addr);
                if (issue_m) begin
                    m_inflight.push_back('{addr: m_fetch, stale: 1'b0});
                    m_fetch = m_fetch + 32'd4;
                end
            end
            m_armed = 1'b1;
        end
    end

    initial begin
        int n84;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        bus.ins_ready      = 1'b0;

        // streaming, 1-cycle memory, decode always ready
        lat = 1; d_mem_ready = 1'b1; d_ins_ready = 1'b1;
        do_reset();
        step(); #1;
        chk("t1_reset_req_valid", 32'(bus.mem_req_valid), 32'h0);
        chk("t1_reset_ins_valid", 32'(bus.ins_valid), 32'h0);
        run(11); #3;
        chk("t1_issued_n", 32'(issued.size()), 32'd11);
        chk("t1_issued0", issued[0], 32'h80);
        chk("t1_issued1", issued[1], 32'h84);
        chk("t1_issued2", issued[2], 32'h88);
        chk("t1_delivered_n", 32'(delivered.size()), 32'd9);
        chk("t1_delivered0", delivered[0], 32'h80);
        chk("t1_delivered8", delivered[8], 32'ha0);

        // decode stalled: queue fills, then drains in order
        lat = 1; d_mem_ready = 1'b1; d_ins_ready = 1'b0;
        do_reset();
        run(10); #1;
        chk("t2_full_req_valid", 32'(bus.mem_req_valid), 32'h0);
        chk("t2_full_ins_valid", 32'(bus.ins_valid), 32'h1);
        chk("t2_full_ins_pc", bus.ins_pc, 32'h80);
        #2;
        chk("t2_issued_n", 32'(issued.size()), 32'd4);
        chk("t2_issued3", issued[3], 32'h8c);
        d_ins_ready = 1'b1;
        run(8); #3;
        chk("t2_delivered_n", 32'(delivered.size()), 32'd8);
        chk("t2_delivered0", delivered[0], 32'h80);
        chk("t2_delivered3", delivered[3], 32'h8c);
        chk("t2_delivered4", delivered[4], 32'h90);
        chk("t2_delivered7", delivered[7], 32'h9c);
        chk("t2_issued_total", 32'(issued.size()), 32'd11);
        chk("t2_issued4", issued[4], 32'h90);

        // memory back-pressure holds the request stable
        lat = 2; d_mem_ready = 1'b1; d_ins_ready = 1'b1;
        do_reset();
        run(2);
        d_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("t3_stall_valid", 32'(bus.mem_req_valid), 32'h1);
            chk("t3_stall_addr", bus.mem_req_addr, 32'h84);
        end
        d_mem_ready = 1'b1;
        run(6); #3;
        n84 = 0;
        foreach (issued[i]) if (issued[i] == 32'h84) n84++;
        chk("t3_one_0x84", 32'(n84), 32'd1);
        chk("t3_issued1", issued[1], 32'h84);
        chk("t3_issued2", issued[2], 32'h88);
        chk("t3_delivered1", delivered[1], 32'h84);

        // redirect with two in flight, no response that cycle
        lat = 3; d_mem_ready = 1'b1; d_ins_ready = 1'b1;
        do_reset();
        run(3);
        d_redirect = 1'b1; d_redirect_pc = 32'h200;
        step(); #1;
        chk("t4_redirect_blocks_req", 32'(bus.mem_req_valid), 32'h0);
        d_redirect = 1'b0;
        step(); #1;
        chk("t4_after_ins_valid", 32'(bus.ins_valid), 32'h0);
        chk("t4_after_req_addr", bus.mem_req_addr, 32'h200);
        run(8); #3;
        chk("t4_issued2", issued[2], 32'h200);
        chk("t4_delivered0", delivered[0], 32'h200);
        chk("t4_delivered1", delivered[1], 32'h204);

        // redirect coinciding with a response and a ready decode
        lat = 3; d_mem_ready = 1'b1; d_ins_ready = 1'b1;
        do_reset();
        run(5);
        d_redirect = 1'b1; d_redirect_pc = 32'h300;
        step(); #1;
        chk("t5_head_before", bus.ins_pc, 32'h80);
        d_redirect = 1'b0;
        step(); #1;
        chk("t5_flushed", 32'(bus.ins_valid), 32'h0);
        run(8); #3;
        chk("t5_delivered0", delivered[0], 32'h300);
        chk("t5_delivered1", delivered[1], 32'h304);

        // back-to-back redirects: the last one wins
        lat = 2; d_mem_ready = 1'b1; d_ins_ready = 1'b1;
        do_reset();
        run(4);
        d_redirect = 1'b1; d_redirect_pc = 32'h400;
        step();
        d_redirect_pc = 32'h500;
        step();
        d_redirect = 1'b0;
        run(8); #3;
        chk("t7_issued3", issued[3], 32'h500);
        chk("t7_delivered0", delivered[0], 32'h500);

        // reset mid-stream with a full-ish queue and one read in flight
        lat = 1; d_mem_ready = 1'b1; d_ins_ready = 1'b0;
        do_reset();
        run(5); #1;
        chk("t6_pre_ins_valid", 32'(bus.ins_valid), 32'h1);
        d_rst_n = 1'b0;
        step();
        d_rst_n = 1'b1; d_ins_ready = 1'b1;
        issued.delete();
        delivered.delete();
        step(); #1;
        chk("t6_post_ins_valid", 32'(bus.ins_valid), 32'h0);
        chk("t6_post_req_valid", 32'(bus.mem_req_valid), 32'h0);
        step(); #1;
        chk("t6_restart_valid", 32'(bus.mem_req_valid), 32'h1);
        chk("t6_restart_addr", bus.mem_req_addr, 32'h80);
        run(6); #3;
        chk("t6_issued0", issued[0], 32'h80);
        chk("t6_delivered0", delivered[0], 32'h80);
        chk("t6_delivered1", delivered[1], 32'h84);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
